// File: rtl/is_uart_tx_framer.sv
// is_uart_tx_framer: UART transmit framer, start/data(LSB first)/parity/stop on a registered txd_o,
// with debug injection of parity and framing errors latched per frame.
module is_uart_tx_framer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_par_err_i,
  input  logic              tx_frt_err_i,
  output logic              tx_ready_o,
  output logic              txd_o,
  output logic              tx_busy_o,
  output logic              tx_done_o
);
  localparam int BAUD_DIV = CLK_HZ / BAUD_RATE;
  localparam int CW = BAUD_DIV > 2 ? $clog2(BAUD_DIV) : 1;

  if (BAUD_DIV < 2) begin : g_div_chk
    $error("is_uart_tx_framer: BAUD_DIV must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("is_uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_width_chk
    $error("is_uart_tx_framer: DATA_W must be 5..9");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [3:0]        idx, idx_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic              par, par_nxt, frt, frt_nxt, txd_nxt;
  logic              tick, accept, data_last, stop_last;

  assign tick      = cnt == CW'(BAUD_DIV - 1);
  assign accept    = state == IDLE && tx_valid_i;
  assign data_last = idx == 4'(DATA_W - 1);
  assign stop_last = idx == 4'(STOP_BITS - 1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      frt   <= 1'b0;
      txd_o <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
      par   <= par_nxt;
      frt   <= frt_nxt;
      txd_o <= txd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = tx_valid_i ? START : IDLE;
      START:   state_nxt = tick ? DATA : START;
      DATA:    state_nxt = tick && data_last ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_nxt = tick ? STOP : PARITY;
      STOP:    state_nxt = tick && stop_last ? IDLE : STOP;
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state == IDLE || tick) ? '0 : cnt + 1'b1;
    idx_nxt = state != state_nxt ? '0 : tick ? idx + 1'b1 : idx;
    sh_nxt  = accept ? tx_data_i : (state == DATA && tick) ? sh >> 1 : sh;
    par_nxt = accept ? (^tx_data_i) ^ 1'(PARITY_ODD) ^ tx_par_err_i : par;
    frt_nxt = accept ? tx_frt_err_i : frt;
  end

  // txd_o is registered, so the line value is chosen from the state being entered
  always_comb begin
    txd_nxt    = state_nxt == START  ? 1'b0 :
                 state_nxt == DATA   ? sh_nxt[0] :
                 state_nxt == PARITY ? par :
                 state_nxt == STOP   ? ~frt : 1'b1;
    tx_ready_o = state == IDLE;
    tx_busy_o  = state != IDLE;
    tx_done_o  = state == STOP && tick && stop_last;
  end
endmodule

// File: tb/tb_is_uart_tx_framer.sv
// tb_is_uart_tx_framer: scoreboard bench; stimulus queues hand-computed line frames,
// per-DUT monitors pop and compare each bit period, done position, gaps and idle state.
module tb_is_uart_tx_framer;
  typedef struct {
    logic [10:0] bits;
    int          gap;
    logic        abort;
  } frame_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       valid1, valid2, pe, fe;
  logic [7:0] data;
  logic       ready1, txd1, busy1, done1;
  logic       ready2, txd2, busy2, done2;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  frame_t     q1[$];
  frame_t     q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  is_uart_tx_framer #(.CLK_HZ(1_000_000), .BAUD_RATE(100_000)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .tx_valid_i(valid1), .tx_data_i(data),
    .tx_par_err_i(pe), .tx_frt_err_i(fe), .tx_ready_o(ready1), .txd_o(txd1),
    .tx_busy_o(busy1), .tx_done_o(done1)
  );

  is_uart_tx_framer #(.CLK_HZ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
    .clk_i(clk), .rstn_i(rstn), .tx_valid_i(valid2), .tx_data_i(data),
    .tx_par_err_i(pe), .tx_frt_err_i(fe), .tx_ready_o(ready2), .txd_o(txd2),
    .tx_busy_o(busy2), .tx_done_o(done2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic monitor(input int w);
    frame_t e;
    logic   t, act, ok, inv, aborted;
    int     cyc_in, done_at, st, prev_st;
    prev_st = -100000;
    forever begin
      @(negedge clk);
      if (!(w != 0 ? busy2 : busy1)) continue;
      st = cyc; inv = 0; done_at = 0; aborted = 0; cyc_in = 0;
      if ((w != 0 ? q2.size() : q1.size()) == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut%0d unexpected_frame: busy at cycle %0d with nothing queued", w + 1, cyc);
        e = '{bits: '1, gap: 0, abort: 1'b0};
      end else e = w != 0 ? q2.pop_front() : q1.pop_front();
      for (int b = 0; b < 11 && !aborted; b++) begin
        ok = 1; act = e.bits[b];
        for (int c = 0; c < 10; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (!rstn) begin aborted = 1; break; end
          cyc_in++;
          t = w != 0 ? txd2 : txd1;
          if (t !== e.bits[b]) begin ok = 0; act = t; end
          if ((w != 0 ? done2 : done1) === 1'b1) done_at = done_at == 0 ? cyc_in : -1;
          if (w != 0 ? ((ready2 && busy2) || (done2 && ready2)) : ((ready1 && busy1) || (done1 && ready1))) inv = 1;
        end
        if (!aborted) begin
          n_cmp++;
          if (!ok) begin
            n_bad++;
            $display("FAIL dut%0d line_bit%0d: got %b expected %b (frame start cycle %0d)", w + 1, b, act, e.bits[b], st);
          end
        end
      end
      chk($sformatf("dut%0d abort", w + 1), int'(aborted), int'(e.abort));
      if (!aborted) begin
        chk($sformatf("dut%0d done_cycle", w + 1), done_at, 110);
        chk($sformatf("dut%0d ready_busy_done_exclusive", w + 1), int'(inv), 0);
        if (e.gap != 0) chk($sformatf("dut%0d start_gap", w + 1), st - prev_st, e.gap);
        prev_st = st;
        @(negedge clk);
        chk($sformatf("dut%0d idle_after_frame(txd,ready,busy)", w + 1),
            w != 0 ? {txd2, ready2, busy2} : {txd1, ready1, busy1}, 3'b110);
      end
    end
  endtask

  task automatic send(input int w, input logic [7:0] d, input logic p, input logic f);
    int n = 0;
    @(negedge clk);
    while (!(w != 0 ? ready2 : ready1) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("send_ready_timeout", 1, 0);
    data = d; pe = p; fe = f;
    if (w != 0) valid2 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    #1 valid1 = 1'b0; valid2 = 1'b0; data = 8'hFF; pe = ~p; fe = ~f;
  endtask

  task automatic wait_idle(input int w);
    int n = 0;
    while (((w != 0 ? q2.size() : q1.size()) != 0 || (w != 0 ? busy2 : busy1)) && n < 400) begin
      @(negedge clk); n++;
    end
    if (n >= 400) chk("frame_end_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0; valid1 = 1'b0; valid2 = 1'b0; data = 8'h00; pe = 1'b0; fe = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset dut1 {txd,ready,busy,done}", {txd1, ready1, busy1, done1}, 4'b1100);
    chk("reset dut2 {txd,ready,busy,done}", {txd2, ready2, busy2, done2}, 4'b1100);
    rstn = 1'b1;
    // 0x55 clean, then with parity error, then 0xA3 with framing error
    q1.push_back('{bits: 11'b10010101010, gap: 0, abort: 1'b0});
    send(0, 8'h55, 1'b0, 1'b0);
    wait_idle(0);
    q1.push_back('{bits: 11'b11010101010, gap: 0, abort: 1'b0});
    send(0, 8'h55, 1'b1, 1'b0);
    wait_idle(0);
    q1.push_back('{bits: 11'b00101000110, gap: 0, abort: 1'b0});
    send(0, 8'hA3, 1'b0, 1'b1);
    wait_idle(0);
    // back-to-back with valid held high: 0x00 then 0xFF
    q1.push_back('{bits: 11'b10000000000, gap: 0, abort: 1'b0});
    q1.push_back('{bits: 11'b10111111110, gap: 111, abort: 1'b0});
    @(negedge clk);
    data = 8'h00; pe = 1'b0; fe = 1'b0; valid1 = 1'b1;
    @(posedge clk);
    #1 data = 8'hFF;
    n = 0;
    while (n < 300) begin
      @(negedge clk); n++;
      if (ready1) begin @(posedge clk); #1 valid1 = 1'b0; break; end
    end
    if (n >= 300) chk("b2b_second_accept_timeout", 1, 0);
    valid1 = 1'b0;
    wait_idle(0);
    // reset during data bit 3 of 0x0F, then a clean 0x0F
    q1.push_back('{bits: 11'b10000011110, gap: 0, abort: 1'b1});
    send(0, 8'h0F, 1'b0, 1'b0);
    repeat (44) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset txd", int'(txd1), 1);
    chk("async_reset busy", int'(busy1), 0);
    chk("async_reset ready", int'(ready1), 1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset ready", int'(ready1), 1);
    q1.push_back('{bits: 11'b10000011110, gap: 0, abort: 1'b0});
    send(0, 8'h0F, 1'b0, 1'b0);
    wait_idle(0);
    // no parity, two stop bits: 0x80
    q2.push_back('{bits: 11'b11100000000, gap: 0, abort: 1'b0});
    send(1, 8'h80, 1'b0, 1'b0);
    wait_idle(1);
    chk("scoreboard_queues_empty", q1.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
